// File: rtl/hwpe_stream_sink_misalign.sv
// Write-side stream realigner: shifts a word-aligned packet up by R bytes with
// generated strobes, appending one flush beat that carries the residual bytes.
module hwpe_stream_sink_misalign #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              clear_i,
  input  logic                              ctrl_realign_i,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]   ctrl_offset_i,
  input  logic                              ctrl_last_i,
  input  logic [DATA_WIDTH-1:0]             stream_i_data_i,
  input  logic [DATA_WIDTH/8-1:0]           stream_i_strb_i,
  input  logic                              stream_i_valid_i,
  output logic                              stream_i_ready_o,
  output logic [DATA_WIDTH-1:0]             stream_o_data_o,
  output logic [DATA_WIDTH/8-1:0]           stream_o_strb_o,
  output logic                              stream_o_valid_o,
  input  logic                              stream_o_ready_i,
  output logic                              busy_o,
  output logic                              done_o
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned OW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_e;

  state_e                  state_q, state_d;
  logic [OW-1:0]           r_q, r_d, r_eff;
  logic                    mis_q, mis_d, mis_eff;
  logic [DATA_WIDTH-1:0]   resid_q, resid_d;
  logic                    done_q, done_d;

  logic                    in_hs, out_hs;
  logic [DATA_WIDTH-1:0]   hi_word, mis_data;
  logic [2*DATA_WIDTH-1:0] cat;
  logic [NB-1:0]           hi_mask;
  int unsigned             shamt;

  // The first beat of a packet must act on the live control inputs.
  always_comb begin
    r_eff   = r_q;
    mis_eff = mis_q;
    if (state_q == IDLE) begin
      r_eff   = ctrl_offset_i;
      mis_eff = ctrl_realign_i & (ctrl_offset_i != '0);
    end
  end

  // Upper bytes are forced to zero in FLUSH so the held beat cannot follow
  // whatever the next packet already presents on the input.
  always_comb begin
    hi_word  = (state_q == FLUSH) ? '0 : stream_i_data_i;
    cat      = {hi_word, resid_q};
    shamt    = (NB - 32'(r_eff)) * 8;
    mis_data = DATA_WIDTH'(cat >> shamt);
    hi_mask  = '1;
    hi_mask  = hi_mask << r_eff;
  end

  always_comb begin
    stream_o_valid_o = stream_i_valid_i;
    stream_i_ready_o = stream_o_ready_i;
    stream_o_data_o  = stream_i_data_i;
    stream_o_strb_o  = stream_i_strb_i;
    if (state_q == FLUSH) begin
      stream_o_valid_o = 1'b1;
      stream_i_ready_o = 1'b0;
      stream_o_data_o  = mis_data;
      stream_o_strb_o  = ~hi_mask;
    end else if (mis_eff) begin
      stream_o_data_o  = mis_data;
      stream_o_strb_o  = (state_q == IDLE) ? hi_mask : '1;
    end
  end

  assign in_hs  = stream_i_valid_i & stream_i_ready_o;
  assign out_hs = stream_o_valid_o & stream_o_ready_i;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    mis_d   = mis_q;
    resid_d = resid_q;
    done_d  = 1'b0;
    if (in_hs) begin
      resid_d = stream_i_data_i;
    end
    if (in_hs && state_q == IDLE) begin
      r_d   = ctrl_offset_i;
      mis_d = mis_eff;
    end
    unique case (state_q)
      IDLE, STREAM: begin
        if (in_hs) begin
          if (!ctrl_last_i) begin
            state_d = STREAM;
          end else if (mis_eff) begin
            state_d = FLUSH;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (out_hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q <= IDLE;
      r_q     <= '0;
      mis_q   <= 1'b0;
      resid_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      mis_q   <= mis_d;
      resid_q <= resid_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

endmodule

// File: tb/tb_hwpe_stream_sink_misalign.sv
// Directed bench for hwpe_stream_sink_misalign at DATA_WIDTH = 32.
module tb_hwpe_stream_sink_misalign;

  logic        clk = 1'b0;
  logic        rst, clr, realign, last;
  logic [1:0]  off;
  logic [31:0] id, od;
  logic [3:0]  is, os;
  logic        iv, ir, ov, ordy, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  logic [35:0] oq[$];
  logic [31:0] pkt_d[$];
  logic [3:0]  pkt_s[$];

  always #5 clk = ~clk;

  hwpe_stream_sink_misalign #(.DATA_WIDTH(32)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .clear_i          (clr),
    .ctrl_realign_i   (realign),
    .ctrl_offset_i    (off),
    .ctrl_last_i      (last),
    .stream_i_data_i  (id),
    .stream_i_strb_i  (is),
    .stream_i_valid_i (iv),
    .stream_i_ready_o (ir),
    .stream_o_data_o  (od),
    .stream_o_strb_o  (os),
    .stream_o_valid_o (ov),
    .stream_o_ready_i (ordy),
    .busy_o           (busy),
    .done_o           (done)
  );

  // Collect every accepted output beat and count done pulses.
  always @(posedge clk) begin
    if (!rst && !clr && ov && ordy) oq.push_back({os, od});
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives pkt_d/pkt_s as one packet; ctrl inputs are scrambled after the first beat.
  task automatic drive_pkt(input logic rl, input logic [1:0] of, input bit end_pkt,
                           input int stall_pct);
    int n;
    bit hs;
    n = pkt_d.size();
    for (int i = 0; i < n; i++) begin
      if (stall_pct > 0)
        while ($urandom_range(0, 99) < stall_pct) begin
          iv = 1'b0; @(posedge clk); #1;
        end
      iv = 1'b1; id = pkt_d[i]; is = pkt_s[i];
      last    = end_pkt && (i == n - 1);
      realign = (i == 0) ? rl : ~rl;
      off     = (i == 0) ? of : ~of;
      hs = 1'b0;
      for (int t = 0; t < 200 && !hs; t++) begin
        @(negedge clk); hs = ir; @(posedge clk); #1;
      end
      if (!hs) begin
        n_checks++; n_fail++;
        $display("FAIL handshake_timeout: beat %0d never accepted, required accept within 200 cycles", i);
      end
    end
    iv = 1'b0; last = 1'b0; off = ~of; realign = ~rl;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 100 && !idle; t++) begin
      @(negedge clk); idle = !busy;
    end
    if (!idle) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: busy_o still 1, required 0 within 100 cycles");
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, ov, ir} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_outputs: busy/done/ov/ir = %b, required 0001", {busy, done, ov, ir});
    end
    ordy = 1'b0; #1;
    n_checks++;
    if (ir !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_follow: in.ready = %b, required 0", ir);
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned_2beat();
    int d0;
    logic [35:0] b;
    oq.delete(); d0 = done_cnt;
    pkt_d = '{32'h44332211, 32'h88776655}; pkt_s = '{4'hf, 4'hf};
    drive_pkt(1'b1, 2'd1, 1'b1, 0);
    wait_idle();
    n_checks++;
    if (oq.size() != 3) begin
      n_fail++; $display("FAIL mis2_count: %0d beats, required 3", oq.size());
    end
    while (oq.size() < 3) oq.push_back('x);
    b = oq[0] & 36'hF_FFFFFF00;
    n_checks++;
    if (b !== 36'hE_33221100) begin n_fail++; $display("FAIL mis2_beat0: %h, required E_33221100", b); end
    b = oq[1];
    n_checks++;
    if (b !== 36'hF_77665544) begin n_fail++; $display("FAIL mis2_beat1: %h, required F_77665544", b); end
    b = oq[2] & 36'hF_000000FF;
    n_checks++;
    if (b !== 36'h1_00000088) begin n_fail++; $display("FAIL mis2_flush: %h, required 1_00000088", b); end
    n_checks++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL mis2_done: %0d pulses, required 1", done_cnt - d0); end
  endtask

  task automatic test_single_beat();
    logic [35:0] b;
    oq.delete();
    pkt_d = '{32'hDDCCBBAA}; pkt_s = '{4'hf};
    drive_pkt(1'b1, 2'd3, 1'b1, 0);
    wait_idle();
    n_checks++;
    if (oq.size() != 2) begin n_fail++; $display("FAIL single_count: %0d beats, required 2", oq.size()); end
    while (oq.size() < 2) oq.push_back('x);
    b = oq[0] & 36'hF_FF000000;
    n_checks++;
    if (b !== 36'h8_AA000000) begin n_fail++; $display("FAIL single_beat0: %h, required 8_AA000000", b); end
    b = oq[1] & 36'hF_00FFFFFF;
    n_checks++;
    if (b !== 36'h7_00DDCCBB) begin n_fail++; $display("FAIL single_flush: %h, required 7_00DDCCBB", b); end
  endtask

  task automatic test_passthrough();
    int d0;
    for (int c = 0; c < 2; c++) begin
      oq.delete(); d0 = done_cnt;
      pkt_d = '{32'hA3A2A1A0, 32'hB3B2B1B0, 32'hC3C2C1C0, 32'hD3D2D1D0};
      pkt_s = '{4'b1111, 4'b0110, 4'b1111, 4'b0110};
      if (c == 0) drive_pkt(1'b1, 2'd0, 1'b1, 0);
      else        drive_pkt(1'b0, 2'd2, 1'b1, 0);
      wait_idle();
      n_checks++;
      if (oq.size() != 4) begin n_fail++; $display("FAIL pass%0d_count: %0d beats, required 4", c, oq.size()); end
      while (oq.size() < 4) oq.push_back('x);
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (oq[k] !== {pkt_s[k], pkt_d[k]}) begin
          n_fail++; $display("FAIL pass%0d_beat%0d: %h, required %h", c, k, oq[k], {pkt_s[k], pkt_d[k]});
        end
      end
      n_checks++;
      if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL pass%0d_done: %0d pulses, required 1", c, done_cnt - d0); end
    end
  endtask

  task automatic test_random_stalls();
    bit stop, pst;
    logic [36:0] prev;
    int r, nexp, g, idx;
    logic [3:0] es;
    logic [31:0] ed, msk;
    for (int p = 0; p < 3; p++) begin
      oq.delete();
      r = $urandom_range(0, 3);
      pkt_d.delete(); pkt_s.delete();
      for (int i = 0; i < 16; i++) begin pkt_d.push_back($urandom); pkt_s.push_back(4'hf); end
      stop = 1'b0; pst = 1'b0;
      fork
        begin drive_pkt(1'b1, 2'(r), 1'b1, 20); stop = 1'b1; end
        while (!stop) begin @(posedge clk); #1; ordy = ($urandom_range(0, 99) >= 20); end
        while (!stop) begin
          @(negedge clk);
          if (pst) begin
            n_checks++;
            if ({ov, os, od} !== prev) begin
              n_fail++; $display("FAIL stall_hold: %h, required %h", {ov, os, od}, prev);
            end
          end
          pst  = ov && !ordy;
          prev = {ov, os, od};
        end
      join
      ordy = 1'b1;
      wait_idle();
      nexp = (r != 0) ? 17 : 16;
      n_checks++;
      if (oq.size() != nexp) begin n_fail++; $display("FAIL rand%0d_count: %0d beats, required %0d", p, oq.size(), nexp); end
      while (oq.size() < nexp) oq.push_back('x);
      for (int k = 0; k < nexp; k++) begin
        es = '0; ed = '0; msk = '0;
        for (int b = 0; b < 4; b++) begin
          g = k * 4 + b; idx = g - r;
          if (idx >= 0 && idx < 64) begin
            es[b] = 1'b1; msk[8*b +: 8] = 8'hFF;
            ed[8*b +: 8] = pkt_d[idx / 4][8 * (idx % 4) +: 8];
          end
        end
        n_checks++;
        if ({oq[k][35:32], oq[k][31:0] & msk} !== {es, ed}) begin
          n_fail++; $display("FAIL rand%0d_beat%0d R=%0d: %h, required %h", p, k, r, {oq[k][35:32], oq[k][31:0] & msk}, {es, ed});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    logic [35:0] b;
    oq.delete(); d0 = done_cnt;
    pkt_d = '{32'h03020100, 32'h07060504}; pkt_s = '{4'hf, 4'hf};
    drive_pkt(1'b1, 2'd2, 1'b1, 0);
    ordy = 1'b0;
    iv = 1'b1; id = 32'hCAFEBABE; is = 4'hf; realign = 1'b1; off = 2'd1; last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({ov, ir, busy, os, od[15:0]} !== {3'b101, 4'b0011, 16'h0706}) begin
        n_fail++; $display("FAIL b2b_flush_hold: ov/ir/busy/strb/data = %b %b %b %b %h, required 1 0 1 0011 0706",
                           ov, ir, busy, os, od[15:0]);
      end
      @(posedge clk); #1;
    end
    ordy = 1'b1;
    pkt_d = '{32'hCAFEBABE}; pkt_s = '{4'hf};
    drive_pkt(1'b1, 2'd1, 1'b1, 0);
    wait_idle();
    n_checks++;
    if (oq.size() != 5) begin n_fail++; $display("FAIL b2b_count: %0d beats, required 5", oq.size()); end
    while (oq.size() < 5) oq.push_back('x);
    b = oq[0] & 36'hF_FFFF0000;
    n_checks++;
    if (b !== 36'hC_01000000) begin n_fail++; $display("FAIL b2b_a0: %h, required C_01000000", b); end
    n_checks++;
    if (oq[1] !== 36'hF_05040302) begin n_fail++; $display("FAIL b2b_a1: %h, required F_05040302", oq[1]); end
    b = oq[3] & 36'hF_FFFFFF00;
    n_checks++;
    if (b !== 36'hE_FEBABE00) begin n_fail++; $display("FAIL b2b_b0: %h, required E_FEBABE00", b); end
    b = oq[4] & 36'hF_000000FF;
    n_checks++;
    if (b !== 36'h1_000000CA) begin n_fail++; $display("FAIL b2b_b_flush: %h, required 1_000000CA", b); end
    n_checks++;
    if (done_cnt - d0 != 2) begin n_fail++; $display("FAIL b2b_done: %0d pulses, required 2", done_cnt - d0); end
  endtask

  task automatic test_abort();
    int d0;
    logic [35:0] b;
    // Reset in STREAM.
    oq.delete(); d0 = done_cnt;
    pkt_d = '{32'h11111111, 32'h22222222}; pkt_s = '{4'hf, 4'hf};
    drive_pkt(1'b1, 2'd1, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({busy, ov} !== 2'b00) begin n_fail++; $display("FAIL rst_stream_idle: busy/ov = %b, required 00", {busy, ov}); end
    repeat (4) begin @(posedge clk); #1; end
    n_checks++;
    if (oq.size() != 2) begin n_fail++; $display("FAIL rst_stream_beats: %0d beats, required 2", oq.size()); end
    // Clear in FLUSH.
    oq.delete();
    pkt_d = '{32'hA5A5A5A5}; pkt_s = '{4'hf};
    drive_pkt(1'b1, 2'd2, 1'b1, 0);
    ordy = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, ov} !== 2'b11) begin n_fail++; $display("FAIL clr_in_flush: busy/ov = %b, required 11", {busy, ov}); end
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    n_checks++;
    if ({busy, ov} !== 2'b00) begin n_fail++; $display("FAIL clr_flush_idle: busy/ov = %b, required 00", {busy, ov}); end
    ordy = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    n_checks++;
    if (oq.size() != 1) begin n_fail++; $display("FAIL clr_no_flush: %0d beats, required 1", oq.size()); end
    n_checks++;
    if (done_cnt != d0) begin n_fail++; $display("FAIL abort_done: %0d pulses, required 0", done_cnt - d0); end
    // Next packet after the aborts.
    oq.delete(); d0 = done_cnt;
    pkt_d = '{32'h13121110, 32'h17161514}; pkt_s = '{4'hf, 4'hf};
    drive_pkt(1'b1, 2'd3, 1'b1, 0);
    wait_idle();
    n_checks++;
    if (oq.size() != 3) begin n_fail++; $display("FAIL post_abort_count: %0d beats, required 3", oq.size()); end
    while (oq.size() < 3) oq.push_back('x);
    b = oq[0] & 36'hF_FF000000;
    n_checks++;
    if (b !== 36'h8_10000000) begin n_fail++; $display("FAIL post_abort_b0: %h, required 8_10000000", b); end
    n_checks++;
    if (oq[1] !== 36'hF_14131211) begin n_fail++; $display("FAIL post_abort_b1: %h, required F_14131211", oq[1]); end
    b = oq[2] & 36'hF_00FFFFFF;
    n_checks++;
    if (b !== 36'h7_00171615) begin n_fail++; $display("FAIL post_abort_flush: %h, required 7_00171615", b); end
    n_checks++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL post_abort_done: %0d pulses, required 1", done_cnt - d0); end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; realign = 1'b0; last = 1'b0; off = '0;
    id = '0; is = '0; iv = 1'b0; ordy = 1'b1;
    test_reset();
    test_misaligned_2beat();
    test_single_beat();
    test_passthrough();
    test_random_stalls();
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
